// File: rtl/muxn_sel_reg_pkg.sv
// -----------------------------------------------------------------------------
// muxn_sel_reg_pkg
//   Shared definitions for the registered N-source write-back selector.
//   - MODE_SEL / MODE_RR : values of the top-level mode input.
//   - DATAWIDTH_DEF      : default data word width, taken from the common
//                          `DATAWIDTH define (falls back to 16 if unset).
//   - wrap_inc()         : pointer increment that wraps at NSRC-1 -> 0.
// -----------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

package muxn_sel_reg_pkg;

  localparam logic MODE_SEL = 1'b0;  // explicit select by cntrl
  localparam logic MODE_RR  = 1'b1;  // round-robin over req

  localparam int DATAWIDTH_DEF = `DATAWIDTH;

  // Next round-robin pointer after source idx wins; wraps to 0 after the last
  // source. Works in int so the caller only truncates once, to its own width.
  function automatic int wrap_inc(input int idx, input int nsrc);
    int nxt;
    nxt = idx + 1;
    if (nxt >= nsrc) nxt = 0;
    return nxt;
  endfunction

endpackage

// File: rtl/muxn_sel_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin search. Starting at ptr, scan upward
//   (wrapping) for the first set bit of req.
//   Parameters:
//     NSRC        number of requesters (2..16)
//   Ports:
//     req         in   NSRC  request vector
//     ptr         in   SELW  search start index
//     gnt_onehot  out  NSRC  one-hot of the winner (0 when no request)
//     gnt_idx     out  SELW  index of the winner (0 when no request)
//     any         out  1     at least one request is set
//   The pointer register itself lives in the parent.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NSRC = 3,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [NSRC-1:0] gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin : search
    int base;
    int idx;
    logic [SELW-1:0] idx_s;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    idx_s      = '0;
    // An out-of-range pointer cannot occur in normal use; treat it as 0 so the
    // wrap arithmetic below stays within one subtraction.
    base = (int'(ptr) < NSRC) ? int'(ptr) : 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = base + k;
      if (idx >= NSRC) idx = idx - NSRC;
      idx_s = idx[SELW-1:0];
      if (!any && req[idx_s]) begin
        any     = 1'b1;
        gnt_idx = idx_s;
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/muxn_sel_reg.sv
// -----------------------------------------------------------------------------
// muxn_sel_reg
//   Registered N-source selector for the register-file write-back path. One
//   source is chosen per cycle, either by explicit index (mode=0) or by
//   round-robin among requesters (mode=1), and captured into a single-entry
//   output register with valid/ready handshake.
//
//   Handshake: a source is consumed in the cycle its gnt bit is high; a source
//   not granted must keep req and its din slice stable. The consumer takes
//   dout in any cycle where dout_valid && out_ready; a new word may be loaded
//   in that same cycle, so one word per cycle is sustained.
//
//   Parameters:
//     WIDTH  data word width (default `DATAWIDTH)
//     NSRC   number of sources, 2..16
//   Ports:
//     clk         in   1           rising-edge clock
//     rst         in   1           synchronous active-high reset
//     mode        in   1           0 = select by cntrl, 1 = round-robin
//     cntrl       in   SELW        explicit source index (mode=0)
//     req         in   NSRC        per-source valid
//     din         in   NSRC*WIDTH  source i at [i*WIDTH +: WIDTH]
//     gnt         out  NSRC        one-hot, combinational, source consumed
//     dout        out  WIDTH       registered selected word
//     dout_valid  out  1           dout holds an unconsumed word
//     src_id      out  SELW        source that produced dout
//     out_ready   in   1           consumer accepts dout this cycle
//
//   Build option: define MUXSEL_ZERO_IDLE_EN to clear dout and src_id to 0
//   on the edge where the output stage drains to empty. Without it they hold
//   the last captured value while idle.
// -----------------------------------------------------------------------------
module muxn_sel_reg
  import muxn_sel_reg_pkg::*;
#(
  parameter int WIDTH = DATAWIDTH_DEF,
  parameter int NSRC  = 3,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SELW-1:0]       cntrl,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC*WIDTH-1:0] din,
  output logic [NSRC-1:0]       gnt,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [SELW-1:0]       src_id,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  src_id_q, src_id_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0] din_arr [NSRC];
  logic [NSRC-1:0]  rr_onehot;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [SELW-1:0]  sel;
  logic             candidate;
  logic             can_load;
  logic             capture;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign din_arr[i] = din[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NSRC(NSRC)) u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any        (rr_any)
  );

  // Explicit select: an index beyond the last source falls back to source 0.
  // Compare one bit wider so NSRC itself is representable when NSRC = 2**SELW.
  always_comb begin
    sel       = '0;
    candidate = 1'b0;
    if (mode == MODE_RR) begin
      sel       = rr_idx;
      candidate = rr_any;
    end else begin
      sel       = ({1'b0, cntrl} >= (SELW+1)'(NSRC)) ? '0 : cntrl;
      candidate = req[sel];
    end
  end

  assign can_load = !valid_q || out_ready;
  assign capture  = candidate && can_load && !rst;

  always_comb begin
    gnt = '0;
    if (capture) gnt[sel] = 1'b1;
  end

  always_comb begin
    dout_d   = dout_q;
    valid_d  = valid_q;
    src_id_d = src_id_q;
    rr_ptr_d = rr_ptr_q;
    if (capture) begin
      dout_d   = din_arr[sel];
      src_id_d = sel;
      valid_d  = 1'b1;
      if (mode == MODE_RR) rr_ptr_d = SELW'(wrap_inc(int'(sel), NSRC));
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
`ifdef MUXSEL_ZERO_IDLE_EN
      dout_d   = '0;
      src_id_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      src_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      src_id_q <= src_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign src_id     = src_id_q;

endmodule

// File: tb/tb_muxn_sel_reg.sv
// -----------------------------------------------------------------------------
// tb_muxn_sel_reg
//   Directed bench for muxn_sel_reg with NSRC=3, WIDTH=16. Inputs change 1 ns
//   after a rising edge; combinational gnt and registered outputs are both
//   checked in that window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_muxn_sel_reg;

  localparam int W = 16;
  localparam int N = 3;
  localparam int S = $clog2(N);

  logic           clk;
  logic           rst;
  logic           mode;
  logic [S-1:0]   cntrl;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic [S-1:0]   src_id;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  muxn_sel_reg #(.WIDTH(W), .NSRC(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .cntrl      (cntrl),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .src_id     (src_id),
    .out_ready  (out_ready)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  initial begin : stim
    logic [W-1:0] exp_idle_dout;
    logic [S-1:0] exp_idle_src;
    logic [W-1:0] rr_data [N];

    rst = 1'b1; mode = 1'b0; cntrl = '0; req = 3'b001; din = '0; out_ready = 1'b0;
    tick();
    tick();
    // reset state; req[0] with cntrl=0 would be a candidate, but rst masks gnt
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_dout",  32'(dout),       32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_src",   32'(src_id),     32'h0);

    rst = 1'b0; req = '0;
    tick();

    // explicit select of source 2
    mode = 1'b0; cntrl = 2'd2; req = 3'b100; set_din(2, 16'hBEEF); out_ready = 1'b1;
    #1 chk("sel2_gnt", 32'(gnt), 32'b100);
    tick();
    chk("sel2_dout",  32'(dout),       32'hBEEF);
    chk("sel2_src",   32'(src_id),     32'd2);
    chk("sel2_valid", 32'(dout_valid), 32'd1);

    // out-of-range select falls back to source 0
    cntrl = 2'd3; req = 3'b001; set_din(0, 16'h1234);
    #1 chk("oor_gnt", 32'(gnt), 32'b001);
    tick();
    chk("oor_dout", 32'(dout),   32'h1234);
    chk("oor_src",  32'(src_id), 32'd0);

    // round-robin, all requesting: 0,1,2,0
    rr_data[0] = 16'h1111; rr_data[1] = 16'h2222; rr_data[2] = 16'h3333;
    for (int i = 0; i < N; i++) set_din(i, rr_data[i]);
    mode = 1'b1; req = 3'b111;
    for (int c = 0; c < 4; c++) begin
      automatic int e = c % N;
      #1 chk($sformatf("rr%0d_gnt", c), 32'(gnt), 32'(1) << e);
      tick();
      chk($sformatf("rr%0d_src", c),   32'(src_id),     32'(e));
      chk($sformatf("rr%0d_dout", c),  32'(dout),       32'(rr_data[e]));
      chk($sformatf("rr%0d_valid", c), 32'(dout_valid), 32'd1);
    end
    // rr_ptr is now 1, dout=1111 from source 0

    // stall: output full, consumer not ready
    mode = 1'b0; cntrl = 2'd1; req = 3'b010; set_din(1, 16'h4444); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_gnt", c), 32'(gnt), 32'h0);
      tick();
      chk($sformatf("stall%0d_dout", c),  32'(dout),       32'h1111);
      chk($sformatf("stall%0d_valid", c), 32'(dout_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("unstall_gnt", 32'(gnt), 32'b010);
    tick();
    chk("unstall_dout", 32'(dout),   32'h4444);
    chk("unstall_src",  32'(src_id), 32'd1);

    // move rr_ptr from 1 to 2 with a single round-robin capture of source 1
    mode = 1'b1; req = 3'b010; set_din(1, 16'h5555);
    #1 chk("ptr_gnt", 32'(gnt), 32'b010);
    tick();
    chk("ptr_src", 32'(src_id), 32'd1);

    // reset mid-operation with dout_valid=1, rr_ptr=2
    rst = 1'b1; req = 3'b111;
    #1 chk("mrst_gnt", 32'(gnt), 32'h0);
    tick();
    chk("mrst_dout",  32'(dout),       32'h0);
    chk("mrst_valid", 32'(dout_valid), 32'd0);
    chk("mrst_src",   32'(src_id),     32'd0);
    rst = 1'b0;
    // pointer back at 0: source 0 wins, not source 2
    #1 chk("post_rst_gnt", 32'(gnt), 32'b001);
    tick();
    chk("post_rst_src",  32'(src_id), 32'd0);
    chk("post_rst_dout", 32'(dout),   32'h1111);
    // rr_ptr now 1

    // idle drain after a single capture of A5A5 from source 1
    mode = 1'b0; cntrl = 2'd1; req = 3'b010; set_din(1, 16'hA5A5);
    tick();
    chk("idle_cap_dout", 32'(dout),   32'hA5A5);
    chk("idle_cap_src",  32'(src_id), 32'd1);
    req = '0;
    #1 chk("idle_gnt", 32'(gnt), 32'h0);
    tick();
`ifdef MUXSEL_ZERO_IDLE_EN
    exp_idle_dout = '0;     exp_idle_src = '0;
`else
    exp_idle_dout = 16'hA5A5; exp_idle_src = 2'd1;
`endif
    chk("idle_valid", 32'(dout_valid), 32'd0);
    chk("idle_dout",  32'(dout),       32'(exp_idle_dout));
    chk("idle_src",   32'(src_id),     32'(exp_idle_src));
    tick();
    chk("idle_hold_valid", 32'(dout_valid), 32'd0);

    // rr_ptr held through mode=0 traffic and the idle period: source 1 next
    mode = 1'b1; req = 3'b111;
    #1 chk("rr_hold_gnt", 32'(gnt), 32'b010);
    tick();
    chk("rr_hold_src", 32'(src_id), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muxn_sel_reg.md
# muxn_sel_reg

Parametrised N-source registered selector for the register-file write-back path.
- Picks one of NSRC data sources, either by explicit select or by round-robin arbitration among requesting sources.
- Registers the chosen word behind a single-entry valid/ready output stage.
- Reports which source won.
- Replaces fixed 3:1 combinational write-back muxing where sources can collide or the consumer can stall.

## Interface
Parameters:
- WIDTH, default `DATAWIDTH (16): data word width.
- NSRC, default 3: number of sources, 2..16.
- SELW (localparam), $clog2(NSRC): select/source-id width.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-high, the only reset.
- mode  in  1  0 = explicit select by cntrl, 1 = round-robin over req.
- cntrl  in  SELW  source index used when mode=0.
- req  in  NSRC  per-source valid; bit i qualifies din slice i.
- din  in  NSRC*WIDTH  flattened source data, source i at [i*WIDTH +: WIDTH].
- gnt  out  NSRC  one-hot, combinational; source consumed this cycle.
- dout  out  WIDTH  registered selected word.
- dout_valid  out  1  dout holds an unconsumed word.
- src_id  out  SELW  index of the source that produced dout.
- out_ready  in  1  consumer accepts dout this cycle.

## Operation
- Effective select (mode=0): sel = cntrl. If cntrl >= NSRC, sel = 0.
- Arbitrated select (mode=1):
  - sel = first index with req set, searching upward from rr_ptr and wrapping.
  - rr_ptr resets to 0.
  - On each mode=1 capture, rr_ptr = sel+1, wrapping NSRC-1 -> 0.
  - rr_ptr is unchanged while mode=0.
- Candidate: mode=0 requires req[sel]=1; mode=1 requires |req=1.
- Output stage accept: can_load = !dout_valid || out_ready.
- Capture = candidate && can_load && !rst. On capture:
  - dout <= din[sel], src_id <= sel, dout_valid <= 1.
  - gnt = one-hot(sel) in the same cycle.
- Otherwise gnt = 0. A source whose req is not granted must hold req and data stable.
- Drain: if dout_valid && out_ready and no capture, dout_valid <= 0.
- Simultaneous drain and capture: new word replaces the old one and dout_valid stays 1. This gives full throughput, one word per cycle.
- Mode or cntrl change takes effect on the decision in the same cycle. No pipeline flush is needed.

## Timing
- Latency: req/din sampled at edge k appear on dout/src_id after edge k, one cycle.
- gnt is combinational from req, mode, cntrl, rr_ptr, dout_valid and out_ready.
- No combinational path from din to dout.
- Reset (edge with rst=1):
  - dout=0, dout_valid=0, src_id=0, rr_ptr=0.
  - gnt forced 0 while rst=1.
  - Any pending word is discarded.
- Stall: dout_valid=1 && out_ready=0 freezes dout, src_id and rr_ptr, and gnt=0.
- No request: dout_valid falls after drain. rr_ptr is held.

## Configuration
- MUXSEL_ZERO_IDLE_EN defined: when dout_valid goes 0 by drain, dout is cleared to 0 on the same edge. src_id is cleared to 0 on that edge as well.
- MUXSEL_ZERO_IDLE_EN undefined: dout and src_id hold the last captured value while idle. This saves the clear logic.
- Both builds: the reset value is 0.

## Structure
- Shared package:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants.
  - WIDTH default tied to `DATAWIDTH from the common defines.
- Sub-module rr_arbiter, parameter NSRC.
  - Inputs req and ptr; outputs gnt_onehot, gnt_idx and any.
  - Purely combinational.
  - The top level owns rr_ptr and the output register.

## Test plan
- Explicit, NSRC=3, WIDTH=16: mode=0, cntrl=2, req=3'b100, din2=16'hBEEF, out_ready=1 -> gnt=3'b100; next cycle dout=BEEF, src_id=2, dout_valid=1.
- Out-of-range select, NSRC=3: cntrl=3, req=3'b001, din0=16'h1234 -> gnt=3'b001, dout=1234, src_id=0.
- Round-robin, mode=1, req=3'b111 held, out_ready=1 for 4 cycles -> src_id sequence 0,1,2,0; gnt one-hot each cycle.
- Stall: dout_valid=1, out_ready=0 for 3 cycles with req=3'b010 -> gnt=0, dout unchanged; first cycle out_ready=1 -> same-cycle capture, dout=din1.
- Reset mid-operation: rst=1 with dout_valid=1 and rr_ptr=2 -> next cycle dout=0, dout_valid=0, gnt=0; after release with mode=1, req=3'b111 -> first grant is source 0.
- Idle drain, checked in both builds: a single capture of 16'hA5A5, then req=0, out_ready=1 -> dout_valid=0 next cycle. dout=0 with MUXSEL_ZERO_IDLE_EN; dout=A5A5 without it.
